rgb_led_arbiter: RTL
====================

Name: rgb_led_arbiter

Overview:
Shares the single on-board RGB LED (led0_r/g/b, active-low) between NUM_REQ status sources, such as heartbeat, button state and error flags.
- Fixed-priority arbitration; index 0 is highest priority.
- Each grant is held for a minimum dwell time so every color stays visible.
- Global PWM brightness control on all three channels.
- Sits between the status generators and the top-level LED pins, and replaces ad-hoc LED muxing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DWELL_CYCLES, 12_000_000, minimum grant hold in clk cycles (1 s at 12 MHz); must be >= 2.
- PWM_BITS, 8, width of the PWM counter and the brightness input.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester display request, level-sensitive.
- req_color  input  3*NUM_REQ  requester i color at bits [3i+2:3i] = {r,g,b}; 1 = lit.
- brightness  input  PWM_BITS  global duty; 0 = off.
- grant  output  NUM_REQ  one-hot current owner; all-zero when idle.
- busy  output  1  high while in HOLD.
- led0_r  output  1  red drive, active-low (1 = off).
- led0_g  output  1  green drive, active-low.
- led0_b  output  1  blue drive, active-low.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: grant=0, busy=0, led0_r/g/b=1, internal state IDLE, dwell counter 0, PWM counter 0, latched color 3'b000, latched brightness 0.
- Reset mid-HOLD aborts immediately; the values above apply after the reset edge.
- State IDLE:
  - If req != 0 at a posedge, then after that edge: grant = lowest set index, busy=1, color latched from req_color of that index, dwell counter = DWELL_CYCLES-1, state = HOLD.
- State HOLD:
  - Dwell counter decrements each cycle.
  - req and req_color changes from the owner are ignored until expiry.
  - The displayed color stays at the latched value, even if the owner drops req.
- Expiry (counter==0 in HOLD), re-arbitrated in that same cycle:
  - req != 0: grant moves to the lowest set index (the owner may win again), color is re-latched and the counter reloads. There is no idle gap, so back-to-back grants are each exactly DWELL_CYCLES long.
  - req == 0: grant=0, busy=0, state = IDLE.
- Simultaneous requests resolve to the lowest index. Fairness is not guaranteed; a persistent low-index requester starves the others by design.
- PWM:
  - Free-running PWM_BITS counter that wraps from all-ones to 0.
  - brightness is sampled into the internal latch only when the counter == 0, so there is no mid-period glitch.
  - on = (pwm_cnt < brightness_latched).
  - led0_x = ~(color_x & on & busy), registered, so there is 1 cycle of latency from state/PWM to the pins.
  - brightness=0 gives the LED always off.
  - brightness = all-ones gives (2^PWM_BITS - 1)/2^PWM_BITS duty.
- In IDLE all LEDs are 1 (off).

Optional Feature:
- Macro: ARB_PREEMPT_EN.
- Defined: during HOLD, if any req with an index strictly lower than the current owner is high at a posedge, then after that edge grant switches to the highest-priority pending index, color is re-latched and the counter reloads to DWELL_CYCLES-1.
  - Equal or lower priority requests never preempt.
  - Preemption and expiry in the same cycle resolve as a normal expiry.
- Undefined: no preemption; the owner always completes its dwell.

Test Plan (DWELL_CYCLES=8, PWM_BITS=4, NUM_REQ=4):
- Reset then idle, req=0 for 20 cycles -> grant=0000, busy=0, led0_r/g/b=1 throughout.
- req=0110, req_color[1]=3'b100, brightness=4'hF -> grant=0010 one cycle after req; led0_r=0 for 15 of every 16 cycles; led0_g=led0_b=1; grant held exactly 8 cycles.
- req=1111 held constant -> grant=0001 is re-granted every 8 cycles with no gap. Then drop req[0] -> grant=0010 at the next expiry boundary.
- Owner drops req on cycle 2 of dwell and nothing else is pending -> color is still shown through cycle 8, then busy=0, grant=0000, LEDs=1.
- brightness changed 4'h2 -> 4'hC mid-PWM-period -> the current period keeps 2/16 duty and the next period shows 12/16 duty. brightness=0 -> LEDs remain 1 while busy=1.
- Assert reset at dwell cycle 4 -> outputs are at reset values the next cycle. With ARB_PREEMPT_EN defined: owner 2, then req[0] rises -> grant=0001 the next cycle with the counter reloaded. Without the macro: grant=0100 until expiry.

Source files
------------

// File: rtl/rgb_led_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rgb_led_arbiter                                               |
// | Purpose  : Fixed-priority, dwell-held sharing of one active-low RGB LED  |
// |            with global PWM brightness. Optional macro: ARB_PREEMPT_EN.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rgb_led_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 12_000_000,
  parameter int PWM_BITS     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_color,
  input  logic [PWM_BITS-1:0]    brightness,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   led0_r,
  output logic                   led0_g,
  output logic                   led0_b
);

  localparam int CNT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t              r_state, w_state_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic [NUM_REQ-1:0]  r_grant, w_grant_n;
  logic                r_busy, w_busy_n;
  logic [2:0]          r_color, w_color_n;
  logic [PWM_BITS-1:0] r_pwm;
  logic [PWM_BITS-1:0] r_bright;
  logic [2:0]          r_led;

  logic [NUM_REQ-1:0]  w_win_onehot;
  logic [2:0]          w_win_color;
  logic                w_any;
  logic                w_pwm_on;

  // Descending scan so the lowest set index is the last (winning) assignment.
  always_comb begin
    w_win_onehot = '0;
    w_win_color  = 3'b000;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_win_onehot    = '0;
        w_win_onehot[i] = 1'b1;
        w_win_color     = req_color[3*i +: 3];
      end
    end
  end

  assign w_any = |req;

`ifdef ARB_PREEMPT_EN
  logic w_preempt;
  // Owner is one-hot in HOLD, so (grant - 1) masks exactly the higher-priority indices.
  assign w_preempt = |(req & (r_grant - NUM_REQ'(1)));
`endif

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_grant_n = r_grant;
    w_busy_n  = r_busy;
    w_color_n = r_color;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_n = S_HOLD;
          w_grant_n = w_win_onehot;
          w_busy_n  = 1'b1;
          w_color_n = w_win_color;
          w_cnt_n   = c_RELOAD;
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          if (w_any) begin
            w_grant_n = w_win_onehot;
            w_color_n = w_win_color;
            w_cnt_n   = c_RELOAD;
          end else begin
            w_state_n = S_IDLE;
            w_grant_n = '0;
            w_busy_n  = 1'b0;
          end
        end
`ifdef ARB_PREEMPT_EN
        else if (w_preempt) begin
          w_grant_n = w_win_onehot;
          w_color_n = w_win_color;
          w_cnt_n   = c_RELOAD;
        end
`endif
        else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_grant_n = '0;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_color <= 3'b000;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_grant <= w_grant_n;
      r_busy  <= w_busy_n;
      r_color <= w_color_n;
    end
  end

  assign w_pwm_on = (r_pwm < r_bright);

  // Brightness only changes at the period start so a duty step never splits a period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm    <= '0;
      r_bright <= '0;
      r_led    <= 3'b111;
    end else begin
      r_pwm <= r_pwm + PWM_BITS'(1);
      if (r_pwm == '0) begin
        r_bright <= brightness;
      end
      r_led <= ~(r_color & {3{w_pwm_on & r_busy}});
    end
  end

  assign grant  = r_grant;
  assign busy   = r_busy;
  assign led0_r = r_led[2];
  assign led0_g = r_led[1];
  assign led0_b = r_led[0];

endmodule
`default_nettype wire
